// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes into little-endian words
// and fills a program memory, in free-running or framed mode.
module uart_word_loader #(
  parameter int WORDS      = 24,
  parameter int WORD_BYTES = 2,
  parameter int FRAMED     = 0,
  parameter int ADDR_BITS  = $clog2(WORDS),
  parameter int CNT_BITS   = $clog2(WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_ready_i,
  output logic                    rx_ack_o,
  output logic                    mem_we_o,
  output logic [ADDR_BITS-1:0]    mem_addr_o,
  output logic [8*WORD_BYTES-1:0] mem_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [CNT_BITS-1:0]     words_loaded_o
);

  localparam int LANE_BITS = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW        = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [LANE_BITS-1:0]   lane;
  logic [DW-1:0]          word_buf;
  logic [DW-1:0]          word_next;
  logic [7:0]             len;
  logic [7:0]             csum;
  logic [7:0]             fcnt;
  logic                   done_q;
  logic                   accept;
  logic                   data_en;
  logic                   last_lane;
  logic                   wr_fire;
  logic [ADDR_BITS-1:0]   addr_inc;
  logic [ADDR_BITS-1:0]   waddr;

  assign accept    = rx_ready_i && rx_ack_o;
  assign data_en   = accept && (FRAMED == 0 || state == S_DATA);
  assign last_lane = (lane == LANE_BITS'(WORD_BYTES - 1));
  assign wr_fire   = data_en && last_lane;
  assign addr_inc  = (mem_addr_o == ADDR_BITS'(WORDS - 1)) ?
                     '0 : mem_addr_o + 1'b1;
  // The address of the next write already accounts for a write
  // in flight this cycle, so back-to-back writes stay in order.
  assign waddr     = mem_we_o ? addr_inc : mem_addr_o;

  assign rx_ack_o = (FRAMED == 0) ||
                    (state inside {S_LEN, S_DATA, S_CSUM});
  assign busy_o   = (lane != '0) ||
                    (FRAMED != 0 && state inside {S_DATA, S_CSUM});
  assign done_o   = (FRAMED != 0) ? (state == S_DONE) : done_q;
  assign error_o  = (FRAMED != 0) && (state == S_ERR);

  // Merge the incoming byte into its lane of the word being built.
  always_comb begin
    word_next = word_buf;
    word_next[8*int'(lane) +: 8] = rx_data_i;
  end

  // Frame sequencing: length header, payload words, checksum byte.
  always_comb begin
    state_next = state;
    if (FRAMED != 0) begin
      unique case (state)
        S_LEN: begin
          if (accept) begin
            if (rx_data_i == 8'd0 || 32'(rx_data_i) > 32'(WORDS))
              state_next = S_ERR;
            else
              state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (wr_fire && (fcnt + 8'd1 == len))
            state_next = S_CSUM;
        end
        S_CSUM: begin
          if (accept) begin
            if (8'(csum + rx_data_i) == 8'd0)
              state_next = S_DONE;
            else
              state_next = S_ERR;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // State, word assembly, write port and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_LEN;
      lane           <= '0;
      word_buf       <= '0;
      len            <= '0;
      csum           <= '0;
      fcnt           <= '0;
      done_q         <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      words_loaded_o <= '0;
    end else begin
      state      <= state_next;
      mem_we_o   <= wr_fire;
      mem_addr_o <= waddr;
      done_q     <= (FRAMED == 0) && wr_fire &&
                    (waddr == ADDR_BITS'(WORDS - 1));
      if (data_en) begin
        csum <= csum + rx_data_i;
        if (last_lane) begin
          lane       <= '0;
          mem_data_o <= word_next;
          fcnt       <= fcnt + 8'd1;
          if (words_loaded_o != CNT_BITS'(WORDS))
            words_loaded_o <= words_loaded_o + 1'b1;
        end else begin
          lane     <= lane + 1'b1;
          word_buf <= word_next;
        end
      end
      if (FRAMED != 0 && state == S_LEN && accept) begin
        len  <= rx_data_i;
        csum <= rx_data_i;
        fcnt <= '0;
      end
    end
  end

endmodule
